// File: rtl/mca_stream_as_accumulator_pkg.sv
// Shared types and width helpers for the streaming analog-state FIR accumulator.
package mca_stream_as_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Coefficient width used for analog state n.
  function automatic int as_width(input int n, input int width_coefficient, input int reduce_step);
    return width_coefficient - n * reduce_step;
  endfunction

  // Accumulator width large enough that K*N full-width terms cannot overflow.
  function automatic int unsigned acc_width(input int unsigned k, input int unsigned n,
                                            input int unsigned width_coefficient);
    return width_coefficient + $clog2(k * n) + 1;
  endfunction

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mca_lane_sum.sv
// Combinational signed +/- sum of one coefficient block at a reduced active width.
module mca_lane_sum #(
  parameter int unsigned LANES             = 16,
  parameter int unsigned WIDTH_COEFFICIENT = 32,
  parameter int unsigned ACC_W             = 44,
  parameter int unsigned WSEL_W            = 6
) (
  input  logic [LANES*WIDTH_COEFFICIENT-1:0] lane_data,
  input  logic [WSEL_W-1:0]                  active_width,
  input  logic [LANES-1:0]                   lane_sign,
  output logic signed [ACC_W-1:0]            sum_c
);

  logic [WSEL_W-1:0]                  shift_c;
  logic signed [WIDTH_COEFFICIENT-1:0] ext_c [LANES];

  // Left-align the active field, then arithmetic-shift back to sign-extend it.
  always_comb begin
    sum_c   = '0;
    shift_c = WSEL_W'(WIDTH_COEFFICIENT) - active_width;
    for (int l = 0; l < int'(LANES); l++) begin
      ext_c[l] = $signed(lane_data[l*WIDTH_COEFFICIENT +: WIDTH_COEFFICIENT] << shift_c) >>> shift_c;
      sum_c    = lane_sign[l] ? (sum_c + ACC_W'(ext_c[l])) : (sum_c - ACC_W'(ext_c[l]));
    end
  end

endmodule

// File: rtl/mca_stream_as_accumulator.sv
// Time-multiplexed FIR accumulator: streams coefficient blocks per analog state into one wide sum.
module mca_stream_as_accumulator
  import mca_stream_as_accumulator_pkg::*;
#(
  parameter int unsigned K                 = 256,
  parameter int unsigned N                 = 8,
  parameter int unsigned LANES             = 16,
  parameter int unsigned WIDTH_COEFFICIENT = 32,
  parameter int unsigned REDUCE_STEP       = 2,
  parameter bit          SATURATE          = 1'b0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [K-1:0][N-1:0]                   S_matrix,
  output logic                                  busy,
  output logic                                  coef_req,
  output logic [idx_width(N)-1:0]               coef_as,
  output logic [idx_width(K/LANES)-1:0]         coef_blk,
  input  logic [LANES*WIDTH_COEFFICIENT-1:0]    coef_rdata,
  output logic signed [WIDTH_COEFFICIENT-1:0]   sample,
  output logic                                  sample_valid,
  output logic                                  overflow
);

  localparam int unsigned NB     = K / LANES;
  localparam int unsigned AS_W   = idx_width(N);
  localparam int unsigned BLK_W  = idx_width(NB);
  localparam int unsigned KI_W   = idx_width(K);
  localparam int unsigned ACC_W  = acc_width(K, N, WIDTH_COEFFICIENT);
  localparam int unsigned WSEL_W = $clog2(WIDTH_COEFFICIENT + 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-WIDTH_COEFFICIENT+1){1'b0}}, {(WIDTH_COEFFICIENT-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-WIDTH_COEFFICIENT+1){1'b1}}, {(WIDTH_COEFFICIENT-1){1'b0}}};

  if ((K % LANES) != 0 || K < LANES) begin : g_bad_k
    $error("K must be a non-zero multiple of LANES");
  end
  if (as_width(int'(N) - 1, int'(WIDTH_COEFFICIENT), int'(REDUCE_STEP)) < 2) begin : g_bad_w
    $error("narrowest analog-state coefficient width must be at least 2");
  end

  state_t                  state;
  logic [K-1:0][N-1:0]     s_lat;
  logic signed [ACC_W-1:0] acc;
  logic                    d_valid;
  logic [AS_W-1:0]         d_as;
  logic [BLK_W-1:0]        d_blk;

  logic [LANES-1:0]        lane_sign_c;
  logic [WSEL_W-1:0]       width_c;
  logic signed [ACC_W-1:0] blk_sum_c;
  logic signed [ACC_W-1:0] acc_next_c;
  logic signed [ACC_W-1:0] clamp_c;
  logic                    out_range_c;
  logic                    last_req_c;

  // Control bits and active width for the block whose data arrives this cycle.
  always_comb begin
    lane_sign_c = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      lane_sign_c[l] = s_lat[KI_W'(int'(K) - 1 - int'(d_blk) * int'(LANES) - l)][d_as];
    end
    width_c = WSEL_W'(as_width(int'(d_as), int'(WIDTH_COEFFICIENT), int'(REDUCE_STEP)));
  end

  mca_lane_sum #(
    .LANES            (LANES),
    .WIDTH_COEFFICIENT(WIDTH_COEFFICIENT),
    .ACC_W            (ACC_W),
    .WSEL_W           (WSEL_W)
  ) u_lane_sum (
    .lane_data   (coef_rdata),
    .active_width(width_c),
    .lane_sign   (lane_sign_c),
    .sum_c       (blk_sum_c)
  );

  always_comb begin
    acc_next_c  = d_valid ? (acc + blk_sum_c) : acc;
    out_range_c = (acc_next_c > SAT_MAX) || (acc_next_c < SAT_MIN);
    clamp_c     = out_range_c ? (acc_next_c[ACC_W-1] ? SAT_MIN : SAT_MAX) : acc_next_c;
    last_req_c  = (coef_as == AS_W'(N - 1)) && (coef_blk == BLK_W'(NB - 1));
  end

  // FSM, request counters, S latch, accumulator and output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      s_lat        <= '0;
      acc          <= '0;
      d_valid      <= 1'b0;
      d_as         <= '0;
      d_blk        <= '0;
      busy         <= 1'b0;
      coef_req     <= 1'b0;
      coef_as      <= '0;
      coef_blk     <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      d_valid <= coef_req;
      d_as    <= coef_as;
      d_blk   <= coef_blk;
      acc     <= acc_next_c;
      unique case (state)
        IDLE: begin
          if (start) begin
            s_lat    <= S_matrix;
            acc      <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            coef_req <= 1'b1;
            coef_as  <= '0;
            coef_blk <= '0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (last_req_c) begin
            coef_req <= 1'b0;
            coef_as  <= '0;
            coef_blk <= '0;
            state    <= DRAIN;
          end else if (coef_blk == BLK_W'(NB - 1)) begin
            coef_blk <= '0;
            coef_as  <= coef_as + AS_W'(1);
          end else begin
            coef_blk <= coef_blk + BLK_W'(1);
          end
        end
        DRAIN: begin
          sample       <= SATURATE ? clamp_c[WIDTH_COEFFICIENT-1:0]
                                   : acc_next_c[WIDTH_COEFFICIENT-1:0];
          overflow     <= out_range_c;
          sample_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          sample_valid <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mca_stream_as_accumulator.sv
// Scoreboard bench: a wrapping and a saturating instance share stimulus; an arithmetic model predicts each sample.
module tb_mca_stream_as_accumulator;

  localparam int K = 8;
  localparam int N = 2;
  localparam int LANES = 4;
  localparam int WC = 16;
  localparam int RS = 2;
  localparam int NB = K / LANES;
  localparam int OPLEN = N * NB;

  typedef struct {
    int     e;
    longint wrap_val;
    longint sat_val;
    int     ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [K-1:0][N-1:0] s_mat = '0;
  logic [WC-1:0] coef [N][K];

  logic busy0, req0, sv0, ov0, busy1, req1, sv1, ov1;
  logic [0:0] as0, blk0, as1, blk1;
  logic [LANES*WC-1:0] rdata0, rdata1;
  logic signed [WC-1:0] sample0, sample1;

  exp_t q[$];
  int cyc = 0;
  int next_ok = 0;
  int nreq = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mca_stream_as_accumulator #(.K(K), .N(N), .LANES(LANES), .WIDTH_COEFFICIENT(WC),
                              .REDUCE_STEP(RS), .SATURATE(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .S_matrix(s_mat), .busy(busy0),
    .coef_req(req0), .coef_as(as0), .coef_blk(blk0), .coef_rdata(rdata0),
    .sample(sample0), .sample_valid(sv0), .overflow(ov0));

  mca_stream_as_accumulator #(.K(K), .N(N), .LANES(LANES), .WIDTH_COEFFICIENT(WC),
                              .REDUCE_STEP(RS), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .S_matrix(s_mat), .busy(busy1),
    .coef_req(req1), .coef_as(as1), .coef_blk(blk1), .coef_rdata(rdata1),
    .sample(sample1), .sample_valid(sv1), .overflow(ov1));

  // One-cycle-latency coefficient store per instance; junk when not requested.
  always @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      rdata0[l*WC +: WC] <= req0 ? coef[int'(as0)][int'(blk0)*LANES + l] : WC'($urandom);
      rdata1[l*WC +: WC] <= req1 ? coef[int'(as1)][int'(blk1)*LANES + l] : WC'($urandom);
    end
  end

  function automatic void chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: signed sum over states and taps with per-state field width.
  function automatic longint ref_sum();
    longint acc = 0;
    for (int n = 0; n < N; n++) begin
      int w = WC - n * RS;
      for (int j = 0; j < K; j++) begin
        longint v = longint'(coef[n][j]) & ((longint'(1) << w) - 1);
        if (v >= (longint'(1) << (w - 1))) v -= (longint'(1) << w);
        acc += s_mat[K-1-j][n] ? v : -v;
      end
    end
    return acc;
  endfunction

  // Acceptance model: a start is taken when the block has been idle long enough.
  always @(posedge clk) begin
    exp_t x;
    longint s;
    longint w;
    cyc = cyc + 1;
    if (reset) begin
      next_ok = 0;
    end else if (start && cyc >= next_ok) begin
      s = ref_sum();
      w = s & 64'hFFFF;
      if (w >= 32768) w -= 65536;
      x.e = cyc;
      x.wrap_val = w;
      x.sat_val = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
      x.ovf = (s > 32767 || s < -32768) ? 1 : 0;
      q.push_back(x);
      next_ok = cyc + OPLEN + 3;
    end
  end

  // Monitor: request sequence, busy, and sample checks against the queue head.
  always @(negedge clk) begin
    exp_t x;
    int k;
    if (!reset) begin
      chk("busy", longint'(busy0), (q.size() > 0) ? 1 : 0);
      chk("busy_sat", longint'(busy1), (q.size() > 0) ? 1 : 0);
      if (req0) begin
        if (q.size() == 0) begin
          chk("unexpected_coef_req", 1, 0);
        end else begin
          k = cyc - q[0].e;
          chk("req_as", longint'(as0), k / NB);
          chk("req_blk", longint'(blk0), k % NB);
          nreq++;
        end
      end
      if (sv0 || sv1) begin
        if (q.size() == 0) begin
          chk("unexpected_sample_valid", 1, 0);
        end else begin
          x = q.pop_front();
          chk("valid_cycle", cyc, x.e + OPLEN + 1);
          chk("valid_wrap_inst", longint'(sv0), 1);
          chk("valid_sat_inst", longint'(sv1), 1);
          chk("sample_wrap", longint'(sample0), x.wrap_val);
          chk("sample_sat", longint'(sample1), x.sat_val);
          chk("overflow_wrap", longint'(ov0), x.ovf);
          chk("overflow_sat", longint'(ov1), x.ovf);
          chk("req_count", nreq, OPLEN);
          nreq = 0;
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, longint'(busy0) + longint'(busy1), 0);
    chk({tag, "_req"}, longint'(req0) + longint'(req1), 0);
    chk({tag, "_as_blk"}, longint'(as0) + longint'(blk0) + longint'(as1) + longint'(blk1), 0);
    chk({tag, "_sample_wrap"}, longint'(sample0), 0);
    chk({tag, "_sample_sat"}, longint'(sample1), 0);
    chk({tag, "_valid"}, longint'(sv0) + longint'(sv1), 0);
    chk({tag, "_overflow"}, longint'(ov0) + longint'(ov1), 0);
  endtask

  task automatic pulse_start();
    @(negedge clk); #2 start = 1'b1;
    @(negedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      chk("timeout_pending", q.size(), 0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic fill(input logic [WC-1:0] v0, input logic [WC-1:0] v1);
    for (int j = 0; j < K; j++) begin
      coef[0][j] = v0;
      coef[1][j] = v1;
    end
  endtask

  initial begin
    fill('0, '0);
    repeat (3) @(negedge clk);
    check_zero("reset");
    #2 reset = 1'b0;

    // Unit coefficients, all positive then all negative.
    fill(16'd1, 16'd1);
    s_mat = '1;
    pulse_start(); wait_idle();
    s_mat = '0;
    pulse_start(); wait_idle();

    // Tap ordering: only the last tap of state 0 is positive.
    for (int j = 0; j < K; j++) begin
      coef[0][j] = WC'(j);
      coef[1][j] = '0;
    end
    s_mat = '0;
    s_mat[0][0] = 1'b1;
    pulse_start(); wait_idle();

    // Narrowed state-1 field: 0xE000 reads as -8192 at 14 bits.
    fill('0, 16'hE000);
    s_mat = '1;
    pulse_start(); wait_idle();

    // Randomized blocks, including junk above the active width.
    for (int t = 0; t < 12; t++) begin
      for (int n = 0; n < N; n++)
        for (int j = 0; j < K; j++)
          coef[n][j] = (t < 4) ? ((j[0]) ? 16'h8000 : 16'h7FFF) : WC'($urandom);
      for (int j = 0; j < K; j++) s_mat[j] = N'($urandom);
      if (t < 2) s_mat = (t == 0) ? '1 : '0;
      pulse_start(); wait_idle();
    end

    // Start held high for 20 cycles.
    fill(16'd3, 16'hFFFD);
    s_mat = '1;
    @(negedge clk); #2 start = 1'b1;
    repeat (20) @(negedge clk);
    #2 start = 1'b0;
    wait_idle();

    // Reset in cycle 3 of an operation aborts without a sample.
    fill(16'd5, 16'd7);
    pulse_start();
    @(negedge clk);
    @(negedge clk); #2 reset = 1'b1;
    q.delete();
    nreq = 0;
    #1 check_zero("midreset");
    @(negedge clk); #2 reset = 1'b0;
    repeat (10) @(negedge clk);
    pulse_start(); wait_idle();

    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
